// File: rtl/masked_parallel_hpc1_pipe.sv
// NUM_MULS parallel HPC1 masked GF(2^BIT_WIDTH) multipliers sharing operand A.
// Two-cycle pipeline with valid tracking and a completed-operation counter.

package aes128_package;
   function automatic int num_quad(input int n);
      return n * (n - 1) / 2;
   endfunction

   function automatic int num_zero_random(input int n);
      return n - 1;
   endfunction

   // Flat index of the cross-term randomness shared by share pair (i, j), i < j.
   function automatic int pair_idx(input int i, input int j, input int n);
      int k;
      k = 0;
      for (int x = 0; x < i; x++) k += n - 1 - x;
      return k + j - i - 1;
   endfunction

   function automatic logic [31:0] gf_poly(input int w);
      case (w)
         2: return 32'h7;
         3: return 32'hB;
         4: return 32'h13;
         5: return 32'h25;
         6: return 32'h43;
         7: return 32'h83;
         8: return 32'h11B;
         default: return 32'h13;
      endcase
   endfunction

   function automatic logic [31:0] gf_mul(input logic [31:0] x, input logic [31:0] y, input int w);
      logic [31:0] acc;
      logic [31:0] xs;
      logic [31:0] poly;
      acc  = '0;
      xs   = x;
      poly = gf_poly(w);
      for (int k = 0; k < w; k++) begin
         if (y[k]) acc = acc ^ xs;
         xs = xs << 1;
         if (xs[w]) xs = xs ^ poly;
      end
      return acc;
   endfunction
endpackage

// Fresh sharing of zero: the last share absorbs the XOR of all others.
module masked_zero #(
   parameter int NUM_SHARES = 2,
   parameter int BIT_WIDTH  = 4,
   localparam int NUM_ZERO_RANDOM = aes128_package::num_zero_random(NUM_SHARES)
) (
   input  logic [NUM_ZERO_RANDOM-1:0][BIT_WIDTH-1:0] r,
   output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]      z
);
   always_comb begin
      z = '0;
      for (int j = 0; j < NUM_SHARES - 1; j++) begin
         z[j]              = r[j];
         z[NUM_SHARES-1]   = z[NUM_SHARES-1] ^ r[j];
      end
   end
endmodule

// HPC1 multiplier: B is refreshed and registered while A arrives one cycle later.
module masked_hpc1_mul #(
   parameter int NUM_SHARES = 2,
   parameter int BIT_WIDTH  = 4,
   localparam int NUM_QUADRATIC = aes128_package::num_quad(NUM_SHARES)
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    en_b,
   input  logic                                    en_u,
   input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]    a,
   input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]    b,
   input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]    z,
   input  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] p,
   output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]    c
);
   logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                  b_ref;
   logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0]  u_d;
   logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0]  u_q;

   for (genvar i = 0; i < NUM_SHARES; i++) begin : g_row
      for (genvar j = 0; j < NUM_SHARES; j++) begin : g_col
         logic [BIT_WIDTH-1:0] prod;
         assign prod = BIT_WIDTH'(aes128_package::gf_mul(32'(a[i]), 32'(b_ref[j]), BIT_WIDTH));
         if (i == j) begin : g_diag
            assign u_d[i][j] = prod;
         end else if (i < j) begin : g_upper
            assign u_d[i][j] = prod ^ p[aes128_package::pair_idx(i, j, NUM_SHARES)];
         end else begin : g_lower
            assign u_d[i][j] = prod ^ p[aes128_package::pair_idx(j, i, NUM_SHARES)];
         end
      end
   end

   // Each cross term is registered before compression so masked products never recombine.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_ref <= '0;
         u_q   <= '0;
      end else begin
         if (en_b) b_ref <= b ^ z;
         if (en_u) u_q   <= u_d;
      end
   end

   always_comb begin
      c = '0;
      for (int i = 0; i < NUM_SHARES; i++)
         for (int j = 0; j < NUM_SHARES; j++)
            c[i] = c[i] ^ u_q[i][j];
   end
endmodule

module masked_parallel_hpc1_pipe #(
   parameter int NUM_SHARES  = 2,
   parameter int BIT_WIDTH   = 4,
   parameter int NUM_MULS    = 2,
   parameter int COUNT_WIDTH = 8,
   localparam int NUM_QUADRATIC   = aes128_package::num_quad(NUM_SHARES),
   localparam int NUM_ZERO_RANDOM = aes128_package::num_zero_random(NUM_SHARES),
   localparam int LATENCY         = 2
) (
   input  logic                                                   in_clock,
   input  logic                                                   in_reset,
   input  logic                                                   in_valid,
   input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                   in_a,
   input  logic [NUM_MULS-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0]     in_b,
   input  logic [NUM_MULS-1:0][NUM_ZERO_RANDOM-1:0][BIT_WIDTH-1:0] in_r_raw,
   input  logic [NUM_MULS-1:0][NUM_QUADRATIC-1:0][BIT_WIDTH-1:0]  in_p,
   output logic                                                   out_valid,
   output logic [NUM_MULS-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0]     out_c,
   output logic [COUNT_WIDTH-1:0]                                 out_count
);
   logic [LATENCY-1:0]                                         vld;
   logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                       a_d;
   logic [NUM_MULS-1:0][NUM_QUADRATIC-1:0][BIT_WIDTH-1:0]      p_d;
   logic [NUM_MULS-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0]         z;

   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         vld       <= '0;
         a_d       <= '0;
         p_d       <= '0;
         out_count <= '0;
      end else begin
         vld <= {vld[LATENCY-2:0], in_valid};
         if (in_valid) begin
            a_d <= in_a;
            p_d <= in_p;
         end
         if (vld[LATENCY-1]) out_count <= out_count + COUNT_WIDTH'(1);
      end
   end

   assign out_valid = vld[LATENCY-1];

   for (genvar m = 0; m < NUM_MULS; m++) begin : g_chan
      masked_zero #(
         .NUM_SHARES (NUM_SHARES),
         .BIT_WIDTH  (BIT_WIDTH)
      ) u_zero (
         .r (in_r_raw[m]),
         .z (z[m])
      );

      masked_hpc1_mul #(
         .NUM_SHARES (NUM_SHARES),
         .BIT_WIDTH  (BIT_WIDTH)
      ) u_mul (
         .clk  (in_clock),
         .rst  (in_reset),
         .en_b (in_valid),
         .en_u (vld[0]),
         .a    (a_d),
         .b    (in_b[m]),
         .z    (z[m]),
         .p    (p_d[m]),
         .c    (out_c[m])
      );
   end
endmodule

// File: doc/masked_parallel_hpc1_pipe.md
MASKED_PARALLEL_HPC1_PIPE -- requirements
Module: masked_parallel_hpc1_pipe

Interface
REQ-001 Parameter NUM_SHARES, default 2: number of Boolean shares per masked value (>=2).
REQ-002 Parameter BIT_WIDTH, default 4: width of one share in bits.
REQ-003 Parameter NUM_MULS, default 2: number of parallel channels, each multiplying the common operand A by its own operand B[i] (>=1).
REQ-004 Parameter COUNT_WIDTH, default 8: width of the completed-operation counter.
REQ-005 Localparams: NUM_QUADRATIC = num_quad(NUM_SHARES); NUM_ZERO_RANDOM = num_zero_random(NUM_SHARES); LATENCY = 2; all from aes128_package.
REQ-006 in_clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 in_reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  operand set on in_a, in_b, in_r_raw, in_p is valid this cycle.
REQ-009 in_a  input  NUM_SHARES x BIT_WIDTH  shared operand A, common to all channels.
REQ-010 in_b  input  NUM_MULS x NUM_SHARES x BIT_WIDTH  per-channel shared operand B[i].
REQ-011 in_r_raw  input  NUM_MULS x NUM_ZERO_RANDOM x BIT_WIDTH  per-channel raw randomness for masked_zero refresh of B[i].
REQ-012 in_p  input  NUM_MULS x NUM_QUADRATIC x BIT_WIDTH  per-channel fresh randomness for the HPC1 cross terms.
REQ-013 out_valid  output  1  out_c holds a new result this cycle.
REQ-014 out_c  output  NUM_MULS x NUM_SHARES x BIT_WIDTH  per-channel shared product C[i] = A*B[i].
REQ-015 out_count  output  COUNT_WIDTH  number of results delivered since reset, modulo 2^COUNT_WIDTH.

Function
REQ-016 Every input, including all randomness, is presented in one cycle t0 with in_valid=1; the block internally delays in_a and in_p by one cycle so that each channel presents A at t1 and B at t0 to its HPC1 multiplier.
REQ-017 Each channel instantiates one masked_zero (fed by in_r_raw[i]) and one masked_hpc1_mul; no randomness is shared between channels or reused across operations.
REQ-018 Unmasked XOR of out_c[i] shares equals the GF(2^BIT_WIDTH) product of XOR(in_a shares) and XOR(in_b[i] shares) as defined by masked_hpc1_mul.
REQ-019 out_valid asserts exactly at t0+LATENCY (cycle t2) for every accepted in_valid, for one cycle per operation.
REQ-020 Fully pipelined: in_valid may be high every cycle; N consecutive valid cycles produce N consecutive out_valid cycles in order.
REQ-021 A 2-bit valid shift register tracks in-flight operations; stage k is set iff an operation entered k+1 cycles ago.
REQ-022 Pipeline registers (delayed A, delayed p, multiplier-internal stages) are clock-enabled by the corresponding valid stage; with in_valid=0 they hold their value, so no share recombination occurs on idle cycles.
REQ-023 out_c holds its last value while out_valid=0; it changes only in cycles where out_valid=1.
REQ-024 out_count increments by 1 in the cycle after each out_valid=1; it wraps from 2^COUNT_WIDTH-1 to 0 without flag.
REQ-025 Input bubbles (in_valid=0 between valid cycles) propagate unchanged: output spacing equals input spacing.

Reset
REQ-026 With in_reset=1 at a rising edge: valid pipeline, out_valid, out_count, delayed-A/p registers and out_c shares all become 0.
REQ-027 Reset has priority over in_valid; an operand presented in a reset cycle is discarded.
REQ-028 Reset mid-operation flushes in-flight operations: no out_valid for any operation accepted before or during reset.
REQ-029 The first operation accepted in the cycle after reset deassertion produces out_valid 2 cycles later.

Verification
REQ-030 Reset, then single op, NUM_MULS=2, A shares XOR to 0, any B -> out_valid only at t2; each out_c[i] shares XOR to 0; out_count 0->1 at t3.
REQ-031 100 back-to-back random ops, random shares and randomness -> 100 consecutive out_valid cycles; each result matches golden GF product; out_count=100.
REQ-032 Ops at t0, t3, t4 (bubbles) -> out_valid at t2, t5, t6 only; out_c stable in all other cycles.
REQ-033 Ops at t0, t1, in_reset=1 at t1 -> no out_valid at t2 or t3; out_count=0; all out_c shares 0.
REQ-034 COUNT_WIDTH=4, 17 ops -> out_count reads 15 after 15th result, 0 after 16th, 1 after 17th.
REQ-035 Same unmasked A, B[i] with two different share/randomness sets -> identical unmasked results, differing share values.
